// File: rtl/rah_div_pkg.sv
// Shared definitions for the sequential restoring divider: widths, bundle field
// positions, FSM state encoding and the result packing helper.
package rah_div_pkg;

  localparam int unsigned DATA_W   = 48;
  localparam int unsigned BUNDLE_W = 3 * DATA_W;

  // Operand bundle: {dividend, divisor, tag}
  localparam int unsigned DIVIDEND_LSB = 2 * DATA_W;
  localparam int unsigned DIVISOR_LSB  = DATA_W;
  localparam int unsigned TAG_LSB      = 0;

  // Result bundle: {quotient, remainder, tag}
  localparam int unsigned QUOT_LSB = 2 * DATA_W;
  localparam int unsigned REM_LSB  = DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [BUNDLE_W-1:0] pack_result(
    input logic [DATA_W-1:0] quot,
    input logic [DATA_W-1:0] rem,
    input logic [DATA_W-1:0] tag
  );
    return {quot, rem, tag};
  endfunction

endpackage

// File: rtl/rah_div_step.sv
// One radix-2 restoring division iteration, purely combinational. The partial
// remainder is one bit wider than the divisor so the trial compare never overflows.
module rah_div_step #(
  parameter int unsigned W = 48
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] q,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic [W-1:0] q_next
);

  logic [W:0] trial;
  logic [W:0] divisor_ext;

  // Shift the next dividend bit into the remainder and subtract when it fits.
  always_comb begin
    trial       = {rem[W-1:0], q[W-1]};
    divisor_ext = {1'b0, divisor};
    if (trial >= divisor_ext) begin
      rem_next = trial - divisor_ext;
      q_next   = {q[W-2:0], 1'b1};
    end else begin
      rem_next = trial;
      q_next   = {q[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rah_div_engine.sv
// Sequential unsigned divider: one quotient bit per clock, one operation in
// flight, tag carried through unchanged. Strobes arriving while busy are
// dropped and counted in a saturating counter.
module rah_div_engine
  import rah_div_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [BUNDLE_W-1:0] in_bundle,
  output logic                out_valid,
  output logic [BUNDLE_W-1:0] out_bundle,
  output logic                div_by_zero,
  output logic                busy,
  output logic [CNT_W-1:0]    drop_count
);

  localparam int unsigned IterW = $clog2(DATA_W);
  localparam logic [IterW-1:0] LastIter = IterW'(DATA_W - 1);

  div_state_e        state_q;
  logic [DATA_W:0]   rem_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] tag_q;
  logic [IterW-1:0]  iter_q;

  logic [DATA_W:0]   rem_step;
  logic [DATA_W-1:0] q_step;

  rah_div_step #(
    .W(DATA_W)
  ) u_step (
    .rem      (rem_q),
    .q        (q_q),
    .divisor  (divisor_q),
    .rem_next (rem_step),
    .q_next   (q_step)
  );

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      tag_q       <= '0;
      iter_q      <= '0;
      out_valid   <= 1'b0;
      out_bundle  <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      drop_count  <= '0;
    end else begin
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;

      // A strobe on the DONE edge is still a drop; the engine is not idle yet.
      if (in_valid && (state_q != IDLE) && (drop_count != {CNT_W{1'b1}})) begin
        drop_count <= drop_count + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            q_q       <= in_bundle[DIVIDEND_LSB +: DATA_W];
            divisor_q <= in_bundle[DIVISOR_LSB +: DATA_W];
            tag_q     <= in_bundle[TAG_LSB +: DATA_W];
            rem_q     <= '0;
            iter_q    <= '0;
            busy      <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          rem_q  <= rem_step;
          q_q    <= q_step;
          iter_q <= iter_q + 1'b1;
          if (iter_q == LastIter) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // Divide by zero needs no special path: the iterations already give
          // all-ones quotient and remainder equal to the dividend.
          out_bundle  <= pack_result(q_q, rem_q[DATA_W-1:0], tag_q);
          out_valid   <= 1'b1;
          div_by_zero <= (divisor_q == '0);
          busy        <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rah_div_engine.sv
// Directed bench for rah_div_engine: reset values, several divisions, divide by
// zero, dropped strobes, mid-operation reset and drop counter saturation.
module tb_rah_div_engine;

  localparam int unsigned W  = 48;
  localparam int unsigned BW = 3 * W;
  localparam logic [W-1:0] Ones = {W{1'b1}};

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [BW-1:0] in_bundle;
  logic          out_valid;
  logic [BW-1:0] out_bundle;
  logic          div_by_zero;
  logic          busy;
  logic [7:0]    drop_count;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  rah_div_engine #(
    .CNT_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bundle   (in_bundle),
    .out_valid   (out_valid),
    .out_bundle  (out_bundle),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count result pulses, sampled mid-cycle.
  always @(negedge clk) if (out_valid === 1'b1) vcount++;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then sample 1 time unit after that edge.
  task automatic drive(input logic v, input logic [BW-1:0] b);
    in_valid  = v;
    in_bundle = b;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; lat is the number of edges waited.
  task automatic wait_result(output int lat);
    lat = 0;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic [W-1:0] t, input logic dz);
    check({tag, "_valid"}, BW'(out_valid), BW'(1'b1));
    check({tag, "_quot"}, BW'(out_bundle[2*W +: W]), BW'(q));
    check({tag, "_rem"}, BW'(out_bundle[W +: W]), BW'(r));
    check({tag, "_tag"}, BW'(out_bundle[0 +: W]), BW'(t));
    check({tag, "_dbz"}, BW'(div_by_zero), BW'(dz));
  endtask

  function automatic logic [BW-1:0] op(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] t);
    return {a, b, t};
  endfunction

  int lat;
  int v0;
  int nres;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_bundle = '0;
    repeat (3) drive(1'b0, '0);

    check("rst_out_valid", BW'(out_valid), '0);
    check("rst_out_bundle", out_bundle, '0);
    check("rst_dbz", BW'(div_by_zero), '0);
    check("rst_busy", BW'(busy), '0);
    check("rst_drop", BW'(drop_count), '0);
    rst = 1'b0;
    drive(1'b0, '0);

    // 100 / 7
    drive(1'b1, op(48'd100, 48'd7, 48'hABC));
    check("a_busy", BW'(busy), BW'(1'b1));
    wait_result(lat);
    check("a_latency", BW'(lat), BW'(49));
    check_result("a", 48'd14, 48'd2, 48'hABC, 1'b0);
    drive(1'b0, '0);
    check("a_pulse_end", BW'(out_valid), '0);
    check("a_idle", BW'(busy), '0);
    check("a_hold", BW'(out_bundle), BW'(op(48'd14, 48'd2, 48'hABC)));

    // Max dividend by 1, then small by larger
    drive(1'b1, op(Ones, 48'd1, 48'h1));
    wait_result(lat);
    check_result("b", Ones, 48'd0, 48'h1, 1'b0);
    drive(1'b1, op(48'd5, 48'd9, 48'h2));
    wait_result(lat);
    check_result("c", 48'd0, 48'd5, 48'h2, 1'b0);

    // Divide by zero
    drive(1'b1, op(48'd1234, 48'd0, 48'h3));
    wait_result(lat);
    check("z_latency", BW'(lat), BW'(49));
    check_result("z", Ones, 48'd1234, 48'h3, 1'b1);
    drive(1'b0, '0);
    check("z_dbz_one_cycle", BW'(div_by_zero), '0);

    // Drops at E+3 and E+49; accept at E+50
    v0 = vcount;
    drive(1'b1, op(48'd1000, 48'd10, 48'h11));      // E
    drive(1'b0, '0);
    drive(1'b0, '0);
    drive(1'b1, op(48'd9, 48'd9, 48'hEE));          // E+3
    repeat (45) drive(1'b0, '0);                    // E+4 .. E+48
    drive(1'b1, op(48'd8, 48'd8, 48'hEF));          // E+49 (DONE edge)
    check_result("d", 48'd100, 48'd0, 48'h11, 1'b0);
    drive(1'b1, op(48'd77, 48'd5, 48'h22));         // E+50
    check("d_drop_count", BW'(drop_count), BW'(2));
    check("d_second_busy", BW'(busy), BW'(1'b1));
    wait_result(lat);
    check("e_latency", BW'(lat), BW'(49));
    check_result("e", 48'd15, 48'd2, 48'h22, 1'b0);
    drive(1'b0, '0);
    check("d_result_count", BW'(vcount - v0), BW'(2));

    // Reset at E+20
    drive(1'b1, op(48'd500, 48'd3, 48'h44));        // E
    repeat (19) drive(1'b0, '0);                    // E+1 .. E+19
    v0 = vcount;
    rst = 1'b1;
    drive(1'b0, '0);                                // E+20
    check("r_out_valid", BW'(out_valid), '0);
    check("r_out_bundle", out_bundle, '0);
    check("r_dbz", BW'(div_by_zero), '0);
    check("r_busy", BW'(busy), '0);
    check("r_drop", BW'(drop_count), '0);
    rst = 1'b0;
    repeat (60) drive(1'b0, '0);
    check("r_no_result", BW'(vcount - v0), '0);
    drive(1'b1, op(48'd1000, 48'd33, 48'h55));
    wait_result(lat);
    check("f_latency", BW'(lat), BW'(49));
    check_result("f", 48'd30, 48'd10, 48'h55, 1'b0);
    drive(1'b0, '0);

    // Saturation: continuous strobes, 7 accepted and 343 dropped over 350 edges
    nres = 0;
    for (int i = 0; i < 350; i++) begin
      drive(1'b1, op(48'd999999, 48'd1000, 48'h77));
      if (out_valid === 1'b1) begin
        nres++;
        check_result("s", 48'd999, 48'd999, 48'h77, 1'b0);
      end
    end
    check("s_result_count", BW'(nres), BW'(7));
    check("s_drop_sat", BW'(drop_count), BW'(255));
    drive(1'b1, op(48'd40, 48'd6, 48'h78));         // accepted (idle)
    drive(1'b1, op(48'd1, 48'd1, 48'h79));          // dropped, counter saturated
    check("s_drop_stays", BW'(drop_count), BW'(255));
    wait_result(lat);
    check("g_latency", BW'(lat), BW'(48));
    check_result("g", 48'd6, 48'd4, 48'h78, 1'b0);
    drive(1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
